// File: rtl/com_bus_arb_pkg.sv
// Shared types and helpers for the common coherence-bus arbiter.
//   arb_state_t  : arbiter FSM states
//   NUM_REQ_DEF  : default requester count (4 D-caches + 4 I-caches)
//   TIMEOUT_DEF  : default owner-hold limit in cycles
//   lowest_set() : index of the lowest set bit of a vector of up to 32 bits
package com_bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OWNED = 3'd1,
    SNOOP = 3'd2,
    MEM   = 3'd3,
    GAP   = 3'd4
  } arb_state_t;

  localparam int unsigned NUM_REQ_DEF = 8;
  localparam int unsigned TIMEOUT_DEF = 1024;

  // Scans downward so the last hit is the lowest set bit; returns 0 for an empty vector.
  function automatic int unsigned lowest_set(input logic [31:0] v);
    lowest_set = 0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (((v >> (i - 1)) & 32'd1) != 32'd0) lowest_set = i - 1;
    end
  endfunction

endpackage

// File: rtl/com_bus_arbiter_rr_pick.sv
// Combinational rotating-priority encoder.
//   i_req   : request vector
//   i_last  : index that won last; search starts at i_last+1 (mod NUM_REQ)
//   o_idx   : winning index (0 when o_valid is low)
//   o_valid : at least one request present
module rr_pick
  import com_bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDXW-1:0]    i_last,
  output logic [IDXW-1:0]    o_idx,
  output logic               o_valid
);

  int unsigned c;

  // Offsets are walked from farthest to nearest so the nearest requester
  // after i_last is the one left in o_idx.
  always_comb begin
    o_idx   = '0;
    o_valid = |i_req;
    c       = 0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      c = (32'(i_last) + k) % NUM_REQ;
      if (((i_req >> c) & NUM_REQ'(1)) != '0) o_idx = IDXW'(c);
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// Common coherence-bus arbiter for the 4-core MESI cache system.
// Grants bus ownership round-robin to one of NUM_REQ cache controllers and,
// inside an ownership window, lends the bus to a snooping cache or to memory.
//   clk, rst_n          : clock, asynchronous active-low reset
//   Com_Bus_Req_proc    : ownership requests        -> Com_Bus_Gnt_proc  (one-hot/zero)
//   Com_Bus_Req_snoop   : snoop-drive requests      -> Com_Bus_Gnt_snoop (one-hot/zero)
//   Mem_snoop_req       : memory fill/writeback req -> Mem_snoop_gnt
//   bus_busy            : any grant active (registered with the grants)
//   arb_timeout         : sticky, owner window lasted TIMEOUT cycles
module com_bus_arbiter
  import com_bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] Com_Bus_Req_proc,
  output logic [NUM_REQ-1:0] Com_Bus_Gnt_proc,
  input  logic [NUM_REQ-1:0] Com_Bus_Req_snoop,
  output logic [NUM_REQ-1:0] Com_Bus_Gnt_snoop,
  input  logic               Mem_snoop_req,
  output logic               Mem_snoop_gnt,
  output logic               bus_busy,
  output logic               arb_timeout
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

  arb_state_t          r_state,     w_state_nxt;
  logic [IDXW-1:0]     r_owner,     w_owner_nxt;
  logic [IDXW-1:0]     r_last,      w_last_nxt;
  logic [IDXW-1:0]     r_snp,       w_snp_nxt;
  logic [NUM_REQ-1:0]  r_gnt_proc,  w_gnt_proc_nxt;
  logic [NUM_REQ-1:0]  r_gnt_snoop, w_gnt_snoop_nxt;
  logic                r_mem_gnt,   w_mem_gnt_nxt;
  logic                r_busy;
  logic                r_timeout,   w_timeout_nxt;
  logic [CNTW-1:0]     r_cnt,       w_cnt_nxt;

  logic [NUM_REQ-1:0]  w_one;
  logic [NUM_REQ-1:0]  w_snoop_cand;
  logic [IDXW-1:0]     w_snoop_idx;
  logic [IDXW-1:0]     w_rr_idx;
  logic                w_rr_valid;

  assign w_one = NUM_REQ'(1);

  // The owner's own snoop request is masked; it already drives the bus.
  assign w_snoop_cand = Com_Bus_Req_snoop & ~(w_one << r_owner);
  assign w_snoop_idx  = IDXW'(lowest_set(32'(w_snoop_cand)));

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr_pick (
    .i_req   (Com_Bus_Req_proc),
    .i_last  (r_last),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_snp_nxt       = r_snp;
    w_gnt_proc_nxt  = r_gnt_proc;
    w_gnt_snoop_nxt = r_gnt_snoop;
    w_mem_gnt_nxt   = r_mem_gnt;
    case (r_state)
      IDLE: begin
        if (w_rr_valid) begin
          w_state_nxt    = OWNED;
          w_owner_nxt    = w_rr_idx;
          w_gnt_proc_nxt = w_one << w_rr_idx;
        end
      end
      OWNED: begin
        // Secondary requests are checked before the owner's release so a
        // release coinciding with a secondary request keeps the window open.
        if (w_snoop_cand != '0) begin
          w_state_nxt     = SNOOP;
          w_snp_nxt       = w_snoop_idx;
          w_gnt_snoop_nxt = w_one << w_snoop_idx;
        end else if (Mem_snoop_req) begin
          w_state_nxt   = MEM;
          w_mem_gnt_nxt = 1'b1;
        end else if (!Com_Bus_Req_proc[r_owner]) begin
          w_state_nxt    = GAP;
          w_gnt_proc_nxt = '0;
          w_last_nxt     = r_owner;
        end
      end
      SNOOP: begin
        if (!Com_Bus_Req_snoop[r_snp]) begin
          w_state_nxt     = OWNED;
          w_gnt_snoop_nxt = '0;
        end
      end
      MEM: begin
        if (!Mem_snoop_req) begin
          w_state_nxt   = OWNED;
          w_mem_gnt_nxt = 1'b0;
        end
      end
      GAP: begin
        w_state_nxt     = IDLE;
        w_gnt_proc_nxt  = '0;
        w_gnt_snoop_nxt = '0;
        w_mem_gnt_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt     = IDLE;
        w_gnt_proc_nxt  = '0;
        w_gnt_snoop_nxt = '0;
        w_mem_gnt_nxt   = 1'b0;
      end
    endcase
  end

  // Hold counter: clears in IDLE, frozen in GAP, saturates at TIMEOUT.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == IDLE) begin
      w_cnt_nxt = '0;
    end else if (r_state != GAP && r_cnt < CNTW'(TIMEOUT)) begin
      w_cnt_nxt = r_cnt + CNTW'(1);
    end
    w_timeout_nxt = r_timeout | (w_cnt_nxt == CNTW'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_last      <= IDXW'(NUM_REQ - 1);
      r_snp       <= '0;
      r_gnt_proc  <= '0;
      r_gnt_snoop <= '0;
      r_mem_gnt   <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_snp       <= w_snp_nxt;
      r_gnt_proc  <= w_gnt_proc_nxt;
      r_gnt_snoop <= w_gnt_snoop_nxt;
      r_mem_gnt   <= w_mem_gnt_nxt;
      r_busy      <= (|w_gnt_proc_nxt) | (|w_gnt_snoop_nxt) | w_mem_gnt_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign Com_Bus_Gnt_proc  = r_gnt_proc;
  assign Com_Bus_Gnt_snoop = r_gnt_snoop;
  assign Mem_snoop_gnt     = r_mem_gnt;
  assign bus_busy          = r_busy;
  assign arb_timeout       = r_timeout;

endmodule

// File: tb/tb_com_bus_arbiter.sv
module tb_com_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] Com_Bus_Req_proc;
  logic [7:0] Com_Bus_Gnt_proc;
  logic [7:0] Com_Bus_Req_snoop;
  logic [7:0] Com_Bus_Gnt_snoop;
  logic       Mem_snoop_req;
  logic       Mem_snoop_gnt;
  logic       bus_busy;
  logic       arb_timeout;

  int n_cmp;
  int n_bad;

  // {gnt_proc, gnt_snoop, mem_gnt, bus_busy, arb_timeout}
  logic [18:0] obs;
  assign obs = {Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, bus_busy, arb_timeout};

  com_bus_arbiter #(
    .NUM_REQ (8),
    .TIMEOUT (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Com_Bus_Req_proc  (Com_Bus_Req_proc),
    .Com_Bus_Gnt_proc  (Com_Bus_Gnt_proc),
    .Com_Bus_Req_snoop (Com_Bus_Req_snoop),
    .Com_Bus_Gnt_snoop (Com_Bus_Gnt_snoop),
    .Mem_snoop_req     (Mem_snoop_req),
    .Mem_snoop_gnt     (Mem_snoop_gnt),
    .bus_busy          (bus_busy),
    .arb_timeout       (arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n             = 1'b0;
    Com_Bus_Req_proc  = '0;
    Com_Bus_Req_snoop = '0;
    Mem_snoop_req     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, 19'h0);
    end
    Com_Bus_Req_snoop = 8'h0F;
    Mem_snoop_req     = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 19'h0) begin
      n_bad++;
      $display("FAIL idle_ignores_secondary: got %h want %h", obs, 19'h0);
    end
  endtask

  // Each step: drive {proc, snoop, mem}, one edge, expect {gp, gs, mgnt, busy, timeout}.
  task automatic test_basic();
    logic [16:0] stim [0:6];
    logic [18:0] expv [0:6];
    stim = '{{8'h81, 8'h00, 1'b0}, {8'h81, 8'h00, 1'b0}, {8'h80, 8'h00, 1'b0},
             {8'h80, 8'h00, 1'b0}, {8'h80, 8'h00, 1'b0}, {8'h00, 8'h00, 1'b0},
             {8'h00, 8'h00, 1'b0}};
    expv = '{{8'h01, 8'h00, 3'b010}, {8'h01, 8'h00, 3'b010}, {8'h00, 8'h00, 3'b000},
             {8'h00, 8'h00, 3'b000}, {8'h80, 8'h00, 3'b010}, {8'h00, 8'h00, 3'b000},
             {8'h00, 8'h00, 3'b000}};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      {Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req} = stim[i];
      tick();
      n_cmp++;
      if (obs !== expv[i]) begin
        n_bad++;
        $display("FAIL basic step %0d: got %h want %h", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    Com_Bus_Req_proc = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      logic [7:0] e;
      e = 8'd1 << (k % 8);
      n_cmp++;
      if ({Com_Bus_Gnt_proc, bus_busy} !== {e, 1'b1}) begin
        n_bad++;
        $display("FAIL rr_grant owner %0d: got %h/%b want %h/1", k % 8, Com_Bus_Gnt_proc, bus_busy, e);
      end
      tick();
      n_cmp++;
      if (Com_Bus_Gnt_proc !== e) begin
        n_bad++;
        $display("FAIL rr_hold owner %0d: got %h want %h", k % 8, Com_Bus_Gnt_proc, e);
      end
      Com_Bus_Req_proc = ~e;
      tick();
      n_cmp++;
      if ({Com_Bus_Gnt_proc, bus_busy} !== 9'h0) begin
        n_bad++;
        $display("FAIL rr_gap owner %0d: got %h/%b want 00/0", k % 8, Com_Bus_Gnt_proc, bus_busy);
      end
      Com_Bus_Req_proc = 8'hFF;
      tick();
      n_cmp++;
      if ({Com_Bus_Gnt_proc, bus_busy} !== 9'h0) begin
        n_bad++;
        $display("FAIL rr_idle owner %0d: got %h/%b want 00/0", k % 8, Com_Bus_Gnt_proc, bus_busy);
      end
      tick();
    end
  endtask

  task automatic test_snoop();
    logic [16:0] stim [0:10];
    logic [18:0] expv [0:10];
    stim = '{{8'h04, 8'h00, 1'b0}, {8'h04, 8'h0A, 1'b0}, {8'h04, 8'h0A, 1'b0},
             {8'h04, 8'h08, 1'b0}, {8'h04, 8'h08, 1'b0}, {8'h04, 8'h04, 1'b0},
             {8'h04, 8'h04, 1'b0}, {8'h04, 8'h04, 1'b0}, {8'h00, 8'h04, 1'b0},
             {8'h00, 8'h04, 1'b0}, {8'h00, 8'h04, 1'b1}};
    expv = '{{8'h04, 8'h00, 3'b010}, {8'h04, 8'h02, 3'b010}, {8'h04, 8'h02, 3'b010},
             {8'h04, 8'h00, 3'b010}, {8'h04, 8'h08, 3'b010}, {8'h04, 8'h00, 3'b010},
             {8'h04, 8'h00, 3'b010}, {8'h04, 8'h00, 3'b010}, {8'h00, 8'h00, 3'b000},
             {8'h00, 8'h00, 3'b000}, {8'h00, 8'h00, 3'b000}};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      {Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req} = stim[i];
      tick();
      n_cmp++;
      if (obs !== expv[i]) begin
        n_bad++;
        $display("FAIL snoop step %0d: got %h want %h", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_mem();
    logic [16:0] stim [0:13];
    logic [18:0] expv [0:13];
    stim = '{{8'h01, 8'h00, 1'b0}, {8'h01, 8'h08, 1'b1}, {8'h01, 8'h08, 1'b1},
             {8'h01, 8'h00, 1'b1}, {8'h01, 8'h00, 1'b1}, {8'h00, 8'h00, 1'b1},
             {8'h00, 8'h00, 1'b1}, {8'h00, 8'h00, 1'b0}, {8'h00, 8'h00, 1'b0},
             {8'h00, 8'h00, 1'b0}, {8'h02, 8'h00, 1'b0}, {8'h00, 8'h00, 1'b1},
             {8'h00, 8'h00, 1'b0}, {8'h00, 8'h00, 1'b0}};
    expv = '{{8'h01, 8'h00, 3'b010}, {8'h01, 8'h08, 3'b010}, {8'h01, 8'h08, 3'b010},
             {8'h01, 8'h00, 3'b010}, {8'h01, 8'h00, 3'b110}, {8'h01, 8'h00, 3'b110},
             {8'h01, 8'h00, 3'b110}, {8'h01, 8'h00, 3'b010}, {8'h00, 8'h00, 3'b000},
             {8'h00, 8'h00, 3'b000}, {8'h02, 8'h00, 3'b010}, {8'h02, 8'h00, 3'b110},
             {8'h02, 8'h00, 3'b010}, {8'h00, 8'h00, 3'b000}};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      {Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req} = stim[i];
      tick();
      n_cmp++;
      if (obs !== expv[i]) begin
        n_bad++;
        $display("FAIL mem step %0d: got %h want %h", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_timeout_and_async_reset();
    do_reset();
    Com_Bus_Req_proc = 8'h01;
    tick();
    n_cmp++;
    if ({Com_Bus_Gnt_proc, arb_timeout} !== {8'h01, 1'b0}) begin
      n_bad++;
      $display("FAIL to_grant: got %h/%b want 01/0", Com_Bus_Gnt_proc, arb_timeout);
    end
    for (int n = 1; n <= 20; n++) begin
      tick();
      n_cmp++;
      if (arb_timeout !== (n >= 16)) begin
        n_bad++;
        $display("FAIL to_cycle %0d: got %b want %b", n, arb_timeout, (n >= 16));
      end
    end
    Com_Bus_Req_proc = 8'h00;
    repeat (3) tick();
    n_cmp++;
    if (obs !== {8'h00, 8'h00, 3'b001}) begin
      n_bad++;
      $display("FAIL to_sticky: got %h want %h", obs, {8'h00, 8'h00, 3'b001});
    end
    Com_Bus_Req_proc = 8'h01;
    tick();
    Com_Bus_Req_snoop = 8'h02;
    tick();
    n_cmp++;
    if (obs !== {8'h01, 8'h02, 3'b011}) begin
      n_bad++;
      $display("FAIL pre_reset: got %h want %h", obs, {8'h01, 8'h02, 3'b011});
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 19'h0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", obs, 19'h0);
    end
    Com_Bus_Req_proc  = 8'hFF;
    Com_Bus_Req_snoop = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (obs !== {8'h01, 8'h00, 3'b010}) begin
      n_bad++;
      $display("FAIL restart_idx0: got %h want %h", obs, {8'h01, 8'h00, 3'b010});
    end
  endtask

  initial begin
    n_cmp             = 0;
    n_bad             = 0;
    rst_n             = 1'b0;
    Com_Bus_Req_proc  = '0;
    Com_Bus_Req_snoop = '0;
    Mem_snoop_req     = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_snoop();
    test_mem();
    test_timeout_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
